// File: rtl/core_pkg.sv
// core_pkg: shared UART types, frame constants and nibble-to-ASCII helper
package core_pkg;
  localparam int UART_FRAME_BITS = 10;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  function automatic logic [7:0] hex2ascii(input logic [3:0] v);
    return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
  endfunction
endpackage

// File: rtl/out_hex_uart_tx_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, read-first on simultaneous push/pop
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    empty = count_q == '0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/out_hex_uart_tx.sv
// out_hex_uart_tx: queues regO changes and sends each as an ASCII hex char on UART 8N1
module out_hex_uart_tx
  import core_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    out_data,
  input  logic                          en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_FRAME_BITS - 3);
  uart_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] last_q, last_d, dout;
  logic tx_q, tx_d, busy_q, busy_d, overflow_q, overflow_d;
  logic push, pop, full, empty, baud_end;
  sync_fifo #(.WIDTH(4), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(out_data),
    .dout(dout), .full(full), .empty(empty), .count(fifo_count)
  );
  // last_q always follows out_data so a change is seen once, even when en=0 or the push drops
  always_comb begin
    last_d = out_data;
    push = en && (out_data != last_q);
  end
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    baud_end = baud_q == BAUD_MAX;
    baud_d = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shift_d = hex2ascii(dout);
        state_d = START;
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (baud_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
        state_d = (bit_q == LAST_BIT) ? STOP : DATA;
      end
      STOP: if (baud_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    busy_d = state_d != IDLE;
    overflow_d = overflow_q || (push && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      last_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      last_q <= last_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      overflow_q <= overflow_d;
    end
  end
  assign tx = tx_q;
  assign busy = busy_q;
  assign overflow = overflow_q;
endmodule
